// File: rtl/uart_loader.sv
// Boot loader: receives a framed program image over UART (8N1) and writes
// 24-bit words into the instruction ROM, holding the CPU until a frame checks out.
module uart_loader #(
  parameter int CLK_HZ       = 27000000,
  parameter int BAUD         = 115200,
  parameter int TIMEOUT_CLKS = 2700000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        uart_rx,
  output logic        prog_w_enable,
  output logic [7:0]  prog_w_addr,
  output logic [23:0] prog_w_data,
  output logic        cpu_hold,
  output logic        loaded,
  output logic        err
);

  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int CW           = $clog2(CLKS_PER_BIT);
  localparam int TW           = $clog2(TIMEOUT_CLKS + 1);

  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CLKS - 1);
  localparam logic [7:0]    HEADER    = 8'hA5;

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_e;
  typedef enum logic [1:0] {L_IDLE, L_LEN, L_DATA, L_CSUM} ld_state_e;

  // ---------------------------------------------------------------------------
  // RX input synchronizer; idles high so reset does not look like a start bit
  // ---------------------------------------------------------------------------
  logic rx_meta_q, rx_sync_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments in clocked blocks so every flop samples
      // the pre-edge value; blocking here would collapse the two stages into one.
      rx_meta_q <= uart_rx;
      rx_sync_q <= rx_meta_q;
    end
  end

  // ---------------------------------------------------------------------------
  // RX FSM
  // ---------------------------------------------------------------------------
  rx_state_e     r_state_q, r_state_d;
  logic [CW-1:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          rx_valid_q, rx_valid_d;
  logic          frame_err_q, frame_err_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state_q   <= R_IDLE;
      clk_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      r_state_q   <= r_state_d;
      clk_cnt_q   <= clk_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    r_state_d   = r_state_q;
    clk_cnt_d   = clk_cnt_q + 1'b1;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
    unique case (r_state_q)
      R_IDLE: begin
        clk_cnt_d = '0;
        if (!rx_sync_q) r_state_d = R_START;
      end
      R_START: begin
        if (clk_cnt_q == HALF_LAST) begin
          clk_cnt_d = '0;
          bit_cnt_d = '0;
          r_state_d = rx_sync_q ? R_IDLE : R_DATA;
        end
      end
      R_DATA: begin
        if (clk_cnt_q == BIT_LAST) begin
          clk_cnt_d = '0;
          shift_d   = {rx_sync_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) r_state_d = R_STOP;
        end
      end
      R_STOP: begin
        if (clk_cnt_q == BIT_LAST) begin
          clk_cnt_d   = '0;
          r_state_d   = R_IDLE;
          rx_valid_d  = rx_sync_q;
          frame_err_d = !rx_sync_q;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Loader FSM; shift_q holds the received byte while rx_valid_q pulses
  // ---------------------------------------------------------------------------
  ld_state_e     l_state_q, l_state_d;
  logic [7:0]    len_q, len_d;
  logic [7:0]    word_idx_q, word_idx_d;
  logic [1:0]    byte_cnt_q, byte_cnt_d;
  logic [15:0]   word_q, word_d;
  logic [7:0]    csum_q, csum_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          prog_w_enable_q, prog_w_enable_d;
  logic [7:0]    prog_w_addr_q, prog_w_addr_d;
  logic [23:0]   prog_w_data_q, prog_w_data_d;
  logic          cpu_hold_q, cpu_hold_d;
  logic          loaded_q, loaded_d;
  logic          err_q, err_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      l_state_q       <= L_IDLE;
      len_q           <= '0;
      word_idx_q      <= '0;
      byte_cnt_q      <= '0;
      word_q          <= '0;
      csum_q          <= '0;
      tmo_q           <= '0;
      prog_w_enable_q <= 1'b0;
      prog_w_addr_q   <= '0;
      prog_w_data_q   <= '0;
      cpu_hold_q      <= 1'b1;
      loaded_q        <= 1'b0;
      err_q           <= 1'b0;
    end else begin
      l_state_q       <= l_state_d;
      len_q           <= len_d;
      word_idx_q      <= word_idx_d;
      byte_cnt_q      <= byte_cnt_d;
      word_q          <= word_d;
      csum_q          <= csum_d;
      tmo_q           <= tmo_d;
      prog_w_enable_q <= prog_w_enable_d;
      prog_w_addr_q   <= prog_w_addr_d;
      prog_w_data_q   <= prog_w_data_d;
      cpu_hold_q      <= cpu_hold_d;
      loaded_q        <= loaded_d;
      err_q           <= err_d;
    end
  end

  always_comb begin
    l_state_d       = l_state_q;
    len_d           = len_q;
    word_idx_d      = word_idx_q;
    byte_cnt_d      = byte_cnt_q;
    word_d          = word_q;
    csum_d          = csum_q;
    tmo_d           = (l_state_q == L_IDLE || rx_valid_q) ? '0 : tmo_q + 1'b1;
    prog_w_enable_d = 1'b0;
    prog_w_addr_d   = prog_w_addr_q;
    prog_w_data_d   = prog_w_data_q;
    cpu_hold_d      = cpu_hold_q;
    loaded_d        = loaded_q;
    err_d           = err_q;

    // A received byte outranks a timeout expiring on the same cycle.
    if (rx_valid_q) begin
      unique case (l_state_q)
        L_IDLE: begin
          if (shift_q == HEADER) begin
            cpu_hold_d = 1'b1;
            loaded_d   = 1'b0;
            err_d      = 1'b0;
            csum_d     = '0;
            word_idx_d = '0;
            byte_cnt_d = '0;
            l_state_d  = L_LEN;
          end
        end
        L_LEN: begin
          len_d     = shift_q;
          l_state_d = L_DATA;
        end
        L_DATA: begin
          word_d = {word_q[7:0], shift_q};
          csum_d = csum_q ^ shift_q;
          if (byte_cnt_q == 2'd2) begin
            byte_cnt_d      = '0;
            prog_w_enable_d = 1'b1;
            prog_w_addr_d   = word_idx_q;
            prog_w_data_d   = {word_q, shift_q};
            word_idx_d      = word_idx_q + 8'd1;
            // Length 0 wraps to 255 here, giving a 256-word frame.
            if (word_idx_q == len_q - 8'd1) l_state_d = L_CSUM;
          end else begin
            byte_cnt_d = byte_cnt_q + 2'd1;
          end
        end
        L_CSUM: begin
          if (shift_q == csum_q) begin
            loaded_d   = 1'b1;
            cpu_hold_d = 1'b0;
          end else begin
            err_d      = 1'b1;
            cpu_hold_d = 1'b1;
          end
          l_state_d = L_IDLE;
        end
        default: l_state_d = L_IDLE;
      endcase
    end else if (l_state_q != L_IDLE && (frame_err_q || tmo_q == TMO_LAST)) begin
      err_d      = 1'b1;
      cpu_hold_d = 1'b1;
      l_state_d  = L_IDLE;
    end
  end

  assign prog_w_enable = prog_w_enable_q;
  assign prog_w_addr   = prog_w_addr_q;
  assign prog_w_data   = prog_w_data_q;
  assign cpu_hold      = cpu_hold_q;
  assign loaded        = loaded_q;
  assign err           = err_q;

endmodule

// File: doc/uart_loader.md
Name: uart_loader

Overview:
- Boot-time program loader upstream of the CPU core.
- Receives a framed program image over a UART RX pin and writes 24-bit instruction words into the instruction ROM's write port.
- Holds the CPU in reset (cpu_hold) until a complete frame with a valid checksum has been loaded.
- Lets the board be reprogrammed without resynthesis.

Parameters:
- CLK_HZ, 27000000, system clock frequency.
- BAUD, 115200, UART bit rate; CLKS_PER_BIT = CLK_HZ/BAUD (integer division, must be >= 8).
- TIMEOUT_CLKS, 2700000, idle clocks allowed between bytes inside a frame before abort.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-low reset.
- uart_rx  in  1  serial input: idle high, 8N1, LSB first.
- prog_w_enable  out  1  one-cycle ROM write strobe.
- prog_w_addr  out  8  ROM word address.
- prog_w_data  out  24  instruction word, first received byte in bits [23:16].
- cpu_hold  out  1  1 = keep CPU in reset.
- loaded  out  1  1 = last frame accepted.
- err  out  1  sticky error flag.

Behaviour:
- Reset (rst low, asynchronous): cpu_hold=1, loaded=0, err=0, prog_w_enable=0, prog_w_addr=0, prog_w_data=0. Loader FSM goes to L_IDLE; RX FSM goes to R_IDLE.
- RX input conditioning: uart_rx passes through a 2-flop synchronizer; the synchronizer resets to 1.
- RX FSM:
  - R_IDLE: wait for synced rx = 0.
  - R_START: count CLKS_PER_BIT/2 clocks, then re-sample. If rx = 1, treat as a glitch and return to R_IDLE with no byte.
  - R_DATA: 8 samples, each taken CLKS_PER_BIT after the previous, LSB first.
  - R_STOP: sample after CLKS_PER_BIT. If 1, assert rx_valid for one cycle with rx_byte. If 0, raise a framing error, produce no byte, and return to R_IDLE.
- Loader FSM (advances only on rx_valid, except on timeout):
  - L_IDLE: 0xA5 is accepted as header; it sets cpu_hold=1, loaded=0, err=0, csum=0, clears the word counter, and moves to L_LEN. Any other byte is ignored.
  - L_LEN: captures N; N=0 means 256 words. Moves to L_DATA.
  - L_DATA: bytes are shifted into a 24-bit word; each byte is XORed into csum.
    - On the 3rd byte of a word: prog_w_data = word, prog_w_addr = word index, and prog_w_enable pulses high for exactly one cycle, the cycle after that rx_valid.
    - The word index then increments, wrapping 255 to 0.
    - After N words, move to L_CSUM.
  - L_CSUM: if byte == csum, set loaded=1 and cpu_hold=0 one cycle after rx_valid. Otherwise set err=1 and keep cpu_hold=1. Either way go to L_IDLE.
- Words already written from a failed frame stay in ROM; cpu_hold guarantees they are never executed.
- Timeout: in L_LEN, L_DATA or L_CSUM, a counter of clocks since the last rx_valid runs. Reaching TIMEOUT_CLKS sets err=1, keeps cpu_hold=1, and returns to L_IDLE. No timeout applies in L_IDLE.
- Framing error outside L_IDLE: err=1, cpu_hold=1, return to L_IDLE. A framing error in L_IDLE is ignored.
- After a successful load, a new 0xA5 header immediately reasserts cpu_hold, so reprogramming restarts the CPU.
- Simultaneous events: an rx_valid and a timeout on the same cycle are resolved in favour of rx_valid.
- Reset mid-frame aborts everything; the partial frame is discarded.
- Only outputs are registered; no combinational path from uart_rx to any output.

Test Plan:
- Bench parameters: CLK_HZ=16*BAUD (16 clocks/bit), TIMEOUT_CLKS=400.
- Reset state: assert rst low mid-simulation -> cpu_hold=1, loaded=0, err=0, prog_w_enable=0 immediately, with no clock edge needed.
- Good frame: 00 A5 02 11 22 33 44 55 66 77 -> leading 00 ignored; writes addr0=0x112233 then addr1=0x445566, one strobe each; then loaded=1, cpu_hold=0, err=0.
- Bad checksum: same frame with last byte 78 -> both writes occur; err=1, cpu_hold=1, loaded=0. A following valid frame clears err and loads.
- Framing/glitch: a 5-clock low pulse on rx -> no byte. A5 01 then a byte with stop bit 0 -> err=1, FSM back to L_IDLE, no write strobe.
- Timeout and reload: A5 01 11 then 400+ idle clocks -> err=1, no write. After a successful load, send A5 -> cpu_hold=1 on the cycle after that header's rx_valid.
